// File: rtl/shift_pkg.sv
// +-----------------------------------------------------------------------+
// | Module : shift_pkg                                                    |
// | Shared state and direction encodings for the sequential shifter.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// +-----------------------------------------------------------------------+
// | Module : shift_step                                                   |
// | Combinational single-step shifter: shifts value by k with fill/rotate.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] k,
    input  logic               dir,
    input  logic               fill,
    input  logic               rotate,
    output logic [WIDTH-1:0]   shifted
);

    logic [WIDTH-1:0]   w_pad;
    logic [2*WIDTH-1:0] w_wide;

    // The operand is extended with either fill bits or a copy of itself, so a
    // plain shift of the double-width word yields shift and rotate alike.
    always_comb begin
        w_pad   = rotate ? value : {WIDTH{fill}};
        w_wide  = '0;
        shifted = '0;
        if (dir == DIR_LEFT) begin
            w_wide  = {value, w_pad} << k;
            shifted = w_wide[2*WIDTH-1:WIDTH];
        end else begin
            w_wide  = {w_pad, value} >> k;
            shifted = w_wide[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_shifter.sv
// +-----------------------------------------------------------------------+
// | Module : seq_shifter                                                  |
// | Multi-cycle left/right logical/arithmetic shifter, STEP bits a cycle. |
// | Optional rotate port enabled by SEQ_SHIFTER_ROTATE_EN.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
`ifdef SEQ_SHIFTER_ROTATE_EN
    input  logic               rotate,
`endif
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    // A step never needs to exceed the largest legal shift amount, which also
    // keeps the constant representable in SHAMT_W bits for tiny widths.
    localparam int STEP_EFF = (STEP > WIDTH - 1) ? (WIDTH - 1) : STEP;
    localparam logic [SHAMT_W-1:0] c_step = SHAMT_W'(STEP_EFF);

    state_e             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_rem;
    logic               r_dir;
    logic               r_fill;
    logic               r_rot;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    logic               w_rot_in;
    logic               w_fill_in;
    logic [SHAMT_W-1:0] w_amt;
    logic [SHAMT_W-1:0] w_rem_nxt;
    logic [WIDTH-1:0]   w_step;

`ifdef SEQ_SHIFTER_ROTATE_EN
    assign w_rot_in = rotate;
`else
    assign w_rot_in = 1'b0;
`endif

    // Sign fill only matters for arithmetic right shifts; left and logical
    // shifts collapse to zero fill here.
    assign w_fill_in = arith & (dir == DIR_RIGHT) & data_in[WIDTH-1];

    assign w_amt     = (r_rem >= c_step) ? c_step : r_rem;
    assign w_rem_nxt = r_rem - w_amt;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .value   (r_work),
        .k       (w_amt),
        .dir     (r_dir),
        .fill    (r_fill),
        .rotate  (r_rot),
        .shifted (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_rem    <= '0;
            r_dir    <= 1'b0;
            r_fill   <= 1'b0;
            r_rot    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work <= data_in;
                        r_rem  <= shamt;
                        r_dir  <= dir;
                        r_fill <= w_fill_in;
                        r_rot  <= w_rot_in;
                        r_busy <= 1'b1;
                        if (shamt != '0) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= data_in;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_step;
                    r_rem  <= w_rem_nxt;
                    if (w_rem_nxt == '0) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_step;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// +-----------------------------------------------------------------------+
// | Module : tb_seq_shifter                                               |
// | Self-checking bench for seq_shifter (WIDTH=32, STEP=2).               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_seq_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 2;
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic               clk     = 1'b0;
    logic               reset   = 1'b1;
    logic               start   = 1'b0;
    logic [WIDTH-1:0]   data_in = '0;
    logic [SHAMT_W-1:0] shamt   = '0;
    logic               dir     = 1'b0;
    logic               arith   = 1'b0;
    logic               rotate  = 1'b0;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    always #5 clk = ~clk;

    seq_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .dir     (dir),
        .arith   (arith),
`ifdef SEQ_SHIFTER_ROTATE_EN
        .rotate  (rotate),
`endif
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    bit chk_en = 1'b0;

    // Literal expectations for the current directed operation.
    bit             lit_valid = 1'b0;
    int             lit_cyc   = 0;
    logic [WIDTH-1:0] lit_res = '0;

    // Reference: whole-amount shift computed directly from the operation.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input int n, input logic dr,
                                                   input logic ar, input logic rt);
        if (rt && n != 0)
            return dr ? ((d << n) | (d >> (WIDTH - n))) : ((d >> n) | (d << (WIDTH - n)));
        if (dr) return d << n;
        if (ar) return WIDTH'($signed(d) >>> n);
        return d >> n;
    endfunction

    // Model state: cycle of first busy, cycle of done, and the visible result.
    bit               m_active = 1'b0;
    int               m_first  = 0;
    int               m_done   = 0;
    logic [WIDTH-1:0] m_pend   = '0;
    logic [WIDTH-1:0] m_result = '0;

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (reset) begin
            m_active <= 1'b0;
            m_result <= '0;
        end else begin
            if (m_active && (ecnt + 1 == m_done))
                m_result <= m_pend;
            if (start && (!m_active || ecnt > m_done)) begin
                m_active <= 1'b1;
                m_first  <= ecnt + 1;
                m_done   <= ecnt + 1 + (int'(shamt) + STEP - 1) / STEP;
                m_pend   <= ref_shift(data_in, int'(shamt), dir, arith, rotate & ROT_EN);
                if (shamt == '0)
                    m_result <= data_in;
            end
        end
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, ecnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", WIDTH'(busy),
                WIDTH'(m_active && ecnt >= m_first && ecnt <= m_done));
            chk("done", WIDTH'(done), WIDTH'(m_active && ecnt == m_done));
            chk("result", result, m_result);
            if (lit_valid && ecnt == lit_cyc) begin
                chk("lit_done", WIDTH'(done), WIDTH'(1));
                chk("lit_result", result, lit_res);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one operation; done expected lat cycles after the start cycle.
    task automatic run_op(input logic [WIDTH-1:0] d, input int s, input logic dr,
                          input logic ar, input logic rt,
                          input logic [WIDTH-1:0] exp, input int lat);
        data_in   = d;
        shamt     = SHAMT_W'(s);
        dir       = dr;
        arith     = ar;
        rotate    = rt;
        start     = 1'b1;
        lit_res   = exp;
        lit_cyc   = ecnt + lat;
        lit_valid = 1'b1;
        cyc(1);
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~SHAMT_W'(s);
        dir     = ~dr;
        arith   = ~ar;
        cyc(lat);
        lit_valid = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk_en = 1'b1;
        reset  = 1'b0;
        cyc(2);

        run_op(32'hCCCCCCCC, 2, 1'b0, 1'b0, 1'b0, 32'h33333333, 2);
        run_op(32'hCCCCCCCC, 2, 1'b0, 1'b1, 1'b0, 32'hF3333333, 2);
        run_op(32'h33333333, 5, 1'b1, 1'b0, 1'b0, 32'h66666660, 4);
        run_op(32'h80000000, 31, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 17);
        run_op(32'h80000000, 31, 1'b0, 1'b0, 1'b0, 32'h00000001, 17);
        run_op(32'hCCCCCCCC, 0, 1'b0, 1'b0, 1'b0, 32'hCCCCCCCC, 1);
        run_op(32'h80000001, 1, 1'b1, 1'b1, 1'b0, 32'h00000002, 2);
        run_op(32'h7FFFFFF0, 3, 1'b0, 1'b1, 1'b0, 32'h0FFFFFFE, 3);

        // Starts during SHIFT and during the DONE cycle must both be dropped.
        data_in = 32'h12345678; shamt = 5'd8; dir = 1'b0; arith = 1'b0;
        start = 1'b1; lit_res = 32'h00123456; lit_cyc = ecnt + 5; lit_valid = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        data_in = 32'hFFFFFFFF; shamt = 5'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        data_in = 32'h0000FFFF; shamt = 5'd0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        lit_valid = 1'b0;

        // Reset in the middle of a long shift aborts it.
        data_in = 32'hCCCCCCCC; shamt = 5'd20; dir = 1'b0; arith = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(3);
        run_op(32'h0000F000, 4, 1'b1, 1'b0, 1'b0, 32'h000F0000, 3);

`ifdef SEQ_SHIFTER_ROTATE_EN
        run_op(32'h80000001, 1, 1'b0, 1'b1, 1'b1, 32'hC0000000, 2);
        run_op(32'hCCCCCCCC, 4, 1'b1, 1'b0, 1'b1, 32'hCCCCCCCC, 3);
        run_op(32'h12345678, 8, 1'b0, 1'b0, 1'b1, 32'h78123456, 5);
`endif

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
